// File: rtl/d_mem_responder.sv
// rtl/d_mem_responder.sv - data-memory responder with programmable wait and shared data bus
module d_mem_responder #(
  parameter int d_addr_bits = 6,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_mem_req,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data,
  output logic                   d_mem_ready,
  output logic                   d_mem_err,
  output logic                   d_mem_busy
);

  localparam int depth = 2 ** (d_addr_bits - 3);
  localparam logic [3:0] lat_init = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, state_next;
  logic [3:0]               cnt, cnt_next;
  logic                     accept;
  logic [d_addr_bits-1:0]   addr_q;
  logic                     we_q;
  logic [63:0]              wdata_q;
  logic [63:0]              mem [depth];
  logic [63:0]              rdata_q;
  logic                     oe_q;

  logic                     enter_resp;
  logic [d_addr_bits-1:0]   c_addr;
  logic                     c_we;
  logic [63:0]              c_wdata;
  logic                     c_err;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (d_mem_req) begin
          accept     = 1'b1;
          cnt_next   = lat_init;
          state_next = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the commit edge is the accept edge, so use live inputs there.
  assign enter_resp = (state_next == RESP);
  assign c_addr     = (state == IDLE) ? d_mem_addr : addr_q;
  assign c_we       = (state == IDLE) ? d_mem_we   : we_q;
  assign c_wdata    = (state == IDLE) ? d_mem_data : wdata_q;
  assign c_err      = (c_addr[2:0] != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      d_mem_ready <= 1'b0;
      d_mem_err   <= 1'b0;
      oe_q        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      d_mem_ready <= enter_resp;
      d_mem_err   <= enter_resp && c_err;
      oe_q        <= enter_resp && !c_we && !c_err;
      if (enter_resp) rdata_q <= mem[c_addr[d_addr_bits-1:3]];
    end
  end

  // Storage and holding registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      addr_q  <= d_mem_addr;
      we_q    <= d_mem_we;
      wdata_q <= d_mem_data;
    end
    if (!rst && enter_resp && c_we && !c_err)
      mem[c_addr[d_addr_bits-1:3]] <= c_wdata;
  end

  assign d_mem_data = oe_q ? rdata_q : 'z;
  assign d_mem_busy = (state != IDLE);

endmodule

// File: tb/tb_d_mem_responder.sv
// tb/tb_d_mem_responder.sv - randomized self-checking bench against a word-array reference model
module tb_d_mem_responder;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req [2];
  logic        we  [2];
  logic [5:0]  addr [2];
  logic [63:0] drv [2];
  logic        oe  [2];
  wire  [63:0] bus0, bus1;
  logic        ready0, ready1, err0, err1, busy0, busy1;

  logic [63:0] ref_mem [2][8];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign bus0 = oe[0] ? drv[0] : 'z;
  assign bus1 = oe[1] ? drv[1] : 'z;

  d_mem_responder #(.d_addr_bits(6), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst[0]), .d_mem_req(req[0]), .d_mem_we(we[0]), .d_mem_addr(addr[0]),
    .d_mem_data(bus0), .d_mem_ready(ready0), .d_mem_err(err0), .d_mem_busy(busy0)
  );

  d_mem_responder #(.d_addr_bits(6), .LATENCY(2)) dut1 (
    .clk(clk), .rst(rst[1]), .d_mem_req(req[1]), .d_mem_we(we[1]), .d_mem_addr(addr[1]),
    .d_mem_data(bus1), .d_mem_ready(ready1), .d_mem_err(err1), .d_mem_busy(busy1)
  );

  function automatic logic [63:0] bus_of(input int i);
    return (i == 0) ? bus0 : bus1;
  endfunction
  function automatic logic ready_of(input int i);
    return (i == 0) ? ready0 : ready1;
  endfunction
  function automatic logic err_of(input int i);
    return (i == 0) ? err0 : err1;
  endfunction
  function automatic logic busy_of(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction
  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access: cycle 0 presents the request, response expected in cycle lat+1.
  task automatic do_access(input int i, input logic w, input logic [5:0] a,
                           input logic [63:0] d, input bit churn, input bit skip);
    int   lat;
    logic aligned;
    lat     = lat_of(i);
    aligned = (a[2:0] == 3'd0);
    if (!skip) step();
    req[i] = 1'b1; we[i] = w; addr[i] = a; oe[i] = 1'b1;
    drv[i] = w ? d : {$urandom, $urandom};
    #1;
    chk("idle_ready", i, 64'(ready_of(i)), 64'd0);
    chk("idle_busy", i, 64'(busy_of(i)), 64'd0);
    chk("idle_bus_z", i, bus_of(i), drv[i]);
    for (int c = 1; c <= lat + 1; c++) begin
      step();
      if (churn && c <= lat) begin
        we[i] = 1'($urandom); addr[i] = 6'($urandom); drv[i] = {$urandom, $urandom};
      end
      if (c == lat + 1) oe[i] = w || !aligned;
      #1;
      chk("busy", i, 64'(busy_of(i)), 64'd1);
      if (c <= lat) begin
        chk("wait_ready", i, 64'(ready_of(i)), 64'd0);
      end else begin
        chk("resp_ready", i, 64'(ready_of(i)), 64'd1);
        chk("resp_err", i, 64'(err_of(i)), 64'(!aligned));
        if (!w && aligned) chk("load_data", i, bus_of(i), ref_mem[i][a[5:3]]);
        else               chk("resp_bus_z", i, bus_of(i), drv[i]);
      end
    end
    if (w && aligned) ref_mem[i][a[5:3]] = d;
    req[i] = 1'b0;
  endtask

  // Store with reset asserted during cycle k (k <= lat: dropped, k = lat+1: committed).
  task automatic do_abort(input int i, input logic [5:0] a, input logic [63:0] d, input int k);
    int lat;
    lat = lat_of(i);
    step();
    req[i] = 1'b1; we[i] = 1'b1; addr[i] = a; drv[i] = d; oe[i] = 1'b1;
    if (k == 0) rst[i] = 1'b1;
    #1;
    chk("abort_c0_busy", i, 64'(busy_of(i)), 64'd0);
    for (int c = 1; c <= k; c++) begin
      step();
      #1;
      chk("abort_busy", i, 64'(busy_of(i)), 64'd1);
      chk("abort_ready", i, 64'(ready_of(i)), 64'(c == lat + 1));
    end
    if (k > 0) begin
      rst[i] = 1'b1; req[i] = 1'b0;
    end
    step();
    req[i] = 1'b0;
    #1;
    chk("after_rst_ready", i, 64'(ready_of(i)), 64'd0);
    chk("after_rst_busy", i, 64'(busy_of(i)), 64'd0);
    chk("after_rst_bus_z", i, bus_of(i), drv[i]);
    rst[i] = 1'b0;
    if (k == lat + 1) ref_mem[i][a[5:3]] = d;
  endtask

  task automatic idle(input int i);
    step();
    req[i] = 1'b0; oe[i] = 1'b1; drv[i] = {$urandom, $urandom};
    #1;
    chk("idle_after_ready", i, 64'(ready_of(i)), 64'd0);
    chk("idle_after_bus_z", i, bus_of(i), drv[i]);
  endtask

  initial begin
    logic [5:0]  ra;
    logic [63:0] rd;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b1; we[i] = 1'b1; addr[i] = 6'd0; oe[i] = 1'b1;
      drv[i] = 64'h0123_4567_89AB_CDEF;
    end

    // Reset held with req high: nothing accepted, bus undriven.
    repeat (2) begin
      step();
      for (int i = 0; i < 2; i++) begin
        chk("rst_ready", i, 64'(ready_of(i)), 64'd0);
        chk("rst_busy", i, 64'(busy_of(i)), 64'd0);
        chk("rst_bus_z", i, bus_of(i), drv[i]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0; req[0] = 1'b0;
    do_access(1, 1'b1, 6'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

    for (int i = 0; i < 2; i++)
      for (int wd = 0; wd < 8; wd++)
        do_access(i, 1'b1, 6'(wd * 8), {$urandom, $urandom}, 1'b0, 1'b0);

    // Store then load at LATENCY=2.
    do_access(1, 1'b1, 6'h10, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    do_access(1, 1'b0, 6'h10, 64'd0, 1'b0, 1'b0);
    idle(1);

    // Zero latency, back-to-back store then load.
    do_access(0, 1'b0, 6'h00, 64'd0, 1'b0, 1'b0);
    do_access(0, 1'b1, 6'h08, 64'hA5A5_0000_FFFF_1234, 1'b0, 1'b0);
    do_access(0, 1'b0, 6'h08, 64'd0, 1'b0, 1'b0);
    idle(0);

    // Misaligned store must not disturb the word.
    do_access(1, 1'b1, 6'h13, 64'h1, 1'b0, 1'b0);
    do_access(1, 1'b0, 6'h10, 64'd0, 1'b0, 1'b0);
    do_access(1, 1'b0, 6'h15, 64'd0, 1'b0, 1'b0);

    // Reset aborts.
    do_abort(1, 6'h18, 64'hFF, 2);
    do_access(1, 1'b0, 6'h18, 64'd0, 1'b0, 1'b0);
    do_abort(1, 6'h18, 64'hFF, 3);
    do_access(1, 1'b0, 6'h18, 64'd0, 1'b0, 1'b0);
    do_abort(1, 6'h20, {$urandom, $urandom}, 1);
    do_access(1, 1'b0, 6'h20, 64'd0, 1'b0, 1'b0);
    do_abort(0, 6'h28, {$urandom, $urandom}, 0);
    do_access(0, 1'b0, 6'h28, 64'd0, 1'b0, 1'b0);
    do_abort(0, 6'h30, {$urandom, $urandom}, 1);
    do_access(0, 1'b0, 6'h30, 64'd0, 1'b0, 1'b0);

    // Input churn during WAIT.
    do_access(1, 1'b1, 6'h38, {$urandom, $urandom}, 1'b1, 1'b0);
    do_access(1, 1'b0, 6'h38, 64'd0, 1'b1, 1'b0);

    // Random mix on both latencies.
    for (int n = 0; n < 80; n++) begin
      int i;
      i  = n % 2;
      ra = 6'($urandom);
      if ($urandom_range(0, 3) != 0) ra[2:0] = 3'd0;
      rd = {$urandom, $urandom};
      do_access(i, 1'($urandom), ra, rd, (i == 1) && ($urandom_range(0, 1) == 1), 1'b0);
      if ($urandom_range(0, 2) == 0) idle(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
